way_select_ctrl: RTL

Lookup and miss-handling controller for a small associative tag directory with 2**ways_p entries. It compares a requested tag against all entries and reports a hit. On a miss it picks a victim, issues a fill request to the next memory level, installs the tag and responds. It sits directly upstream of the tree-PLRU index tracker:
- it drives that tracker's access strobe and way index;
- it consumes the tracker's LRU index as the miss victim.

---
 rtl/way_select_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/way_select_ctrl.sv
// Lookup / miss-handling controller for a 2**ways_p entry associative tag directory.
// Optional WAY_SELECT_INVALID_FIRST_EN: on a miss, prefer the lowest-index invalid entry over the PLRU victim.
module way_select_ctrl #(
  parameter int unsigned ways_p      = 2,
  parameter int unsigned tag_width_p = 20
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   req_v_i,
  output logic                   req_ready_o,
  input  logic [tag_width_p-1:0] req_tag_i,
  input  logic                   flush_i,
  output logic                   resp_v_o,
  input  logic                   resp_ready_i,
  output logic                   resp_hit_o,
  output logic [ways_p-1:0]      resp_way_o,
  output logic                   fill_v_o,
  input  logic                   fill_ready_i,
  output logic [tag_width_p-1:0] fill_tag_o,
  input  logic                   fill_done_i,
  output logic                   lru_v_o,
  output logic [ways_p-1:0]      lru_way_o,
  input  logic [ways_p-1:0]      lru_victim_i
);

  localparam int unsigned entries_lp = 1 << ways_p;

  typedef enum logic [2:0] {IDLE, CMP, FILL_REQ, FILL_WAIT, RESP} state_e;

  state_e                 state_q, state_n;
  logic [tag_width_p-1:0] tag_r [entries_lp];
  logic [entries_lp-1:0]  valid_r;
  logic [tag_width_p-1:0] tag_q;
  logic [ways_p-1:0]      way_q;
  logic                   hit_q;

  logic                   hit_found;
  logic [ways_p-1:0]      hit_way;
  logic [ways_p-1:0]      victim_way;
  logic                   fill_complete;

  // Lowest matching index wins should duplicates ever appear.
  always_comb begin
    hit_found = 1'b0;
    hit_way   = '0;
    for (int unsigned i = 0; i < entries_lp; i++) begin
      if (!hit_found && valid_r[i] && (tag_r[i] == tag_q)) begin
        hit_found = 1'b1;
        hit_way   = ways_p'(i);
      end
    end
  end

`ifdef WAY_SELECT_INVALID_FIRST_EN
  logic inv_found;
  always_comb begin
    inv_found  = 1'b0;
    victim_way = lru_victim_i;
    for (int unsigned i = 0; i < entries_lp; i++) begin
      if (!inv_found && !valid_r[i]) begin
        inv_found  = 1'b1;
        victim_way = ways_p'(i);
      end
    end
  end
`else
  assign victim_way = lru_victim_i;
`endif

  // Same-cycle fill_done with the fill handshake completes the miss directly.
  assign fill_complete = ((state_q == FILL_REQ) && fill_ready_i && fill_done_i) ||
                         ((state_q == FILL_WAIT) && fill_done_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:      if (!flush_i && req_v_i) state_n = CMP;
      CMP:       state_n = hit_found ? RESP : FILL_REQ;
      FILL_REQ:  if (fill_ready_i) state_n = fill_done_i ? RESP : FILL_WAIT;
      FILL_WAIT: if (fill_done_i) state_n = RESP;
      RESP:      if (resp_ready_i) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_r <= '0;
      tag_q   <= '0;
      way_q   <= '0;
      hit_q   <= 1'b0;
      for (int unsigned i = 0; i < entries_lp; i++) tag_r[i] <= '0;
    end else begin
      if (state_q == IDLE) begin
        if (flush_i)      valid_r <= '0;
        else if (req_v_i) tag_q   <= req_tag_i;
      end
      if (state_q == CMP) begin
        hit_q <= hit_found;
        way_q <= hit_found ? hit_way : victim_way;
      end
      if (fill_complete) begin
        tag_r[way_q]   <= tag_q;
        valid_r[way_q] <= 1'b1;
      end
    end
  end

  always_comb begin
    req_ready_o = (state_q == IDLE) && !flush_i;
    resp_v_o    = (state_q == RESP);
    resp_hit_o  = (state_q == RESP) && hit_q;
    resp_way_o  = (state_q == RESP) ? way_q : '0;
    fill_v_o    = (state_q == FILL_REQ);
    fill_tag_o  = (state_q == FILL_REQ) ? tag_q : '0;
    lru_v_o     = 1'b0;
    lru_way_o   = '0;
    if ((state_q == CMP) && hit_found) begin
      lru_v_o   = 1'b1;
      lru_way_o = hit_way;
    end else if (fill_complete) begin
      lru_v_o   = 1'b1;
      lru_way_o = way_q;
    end
  end

endmodule
